// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// The sub signal exists only when PIPE_ADDER_SUB_EN is defined.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Source/sink side (operand producer and result consumer).
    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
`ifdef PIPE_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf
    );

    // Adder side.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
`ifdef PIPE_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit ripple-carry adder split into STAGES chunks of
// CW = WIDTH/STAGES bits, one chunk per clock, carry registered between
// stages, valid/ready on both sides with a single global advance.
// Optional feature macro: PIPE_ADDER_SUB_EN (adds the sub port; sub=1
// computes A + ~B + 1, ignoring cin).
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic adv;

    // Ripple chain of full-adder cells over one chunk; returns {carry_out, sum}.
    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic          c_in
    );
        logic [CW-1:0] s;
        logic          c;
        c = c_in;
        s = '0;
        for (int i = 0; i < CW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Operand bits still pending when entering stage k, and sum bits done after it.
        localparam int IN_W  = WIDTH - k * CW;
        localparam int SUM_W = (k + 1) * CW;

        logic              valid_in;
        logic              carry_in;
        logic [IN_W-1:0]   a_in;
        logic [IN_W-1:0]   b_in;
        logic [CW:0]       add_r;
        logic [SUM_W-1:0]  sum_d;
        logic [SUM_W-1:0]  sum_q;
        logic              valid_d;
        logic              valid_q;
        logic              carry_d;
        logic              carry_q;

        if (k == 0) begin : g_src
            assign valid_in = bus.in_valid;
            assign a_in     = bus.a;
`ifdef PIPE_ADDER_SUB_EN
            // Subtraction folds into the add: invert B once here and force carry-in.
            assign b_in     = bus.sub ? ~bus.b : bus.b;
            assign carry_in = bus.sub | bus.cin;
`else
            assign b_in     = bus.b;
            assign carry_in = bus.cin;
`endif
            assign sum_d    = add_r[CW-1:0];
        end else begin : g_src
            assign valid_in = g_stg[k-1].valid_q;
            assign carry_in = g_stg[k-1].carry_q;
            assign a_in     = g_stg[k-1].g_pend.a_q;
            assign b_in     = g_stg[k-1].g_pend.b_q;
            assign sum_d    = {add_r[CW-1:0], g_stg[k-1].sum_q};
        end

        // Add this stage's chunk with the incoming carry.
        always_comb begin
            add_r   = chunk_add(a_in[CW-1:0], b_in[CW-1:0], carry_in);
            valid_d = valid_in;
            carry_d = add_r[CW];
        end

        // Stage registers advance together; bubbles travel like data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_pend
            logic [IN_W-CW-1:0] a_d;
            logic [IN_W-CW-1:0] a_q;
            logic [IN_W-CW-1:0] b_d;
            logic [IN_W-CW-1:0] b_q;

            // Drop the chunk consumed here; the rest travels to the next stage.
            always_comb begin
                a_d = a_in[IN_W-1:CW];
                b_d = b_in[IN_W-1:CW];
            end

            // Pending high operand chunks.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_msb
            logic cmsb_d;
            logic cmsb_q;

            // Carry into the MSB recovered from the MSB sum bit (s = a ^ b ^ c).
            always_comb begin
                cmsb_d = a_in[CW-1] ^ b_in[CW-1] ^ add_r[CW-1];
            end

            // Carry into MSB, kept for the signed-overflow output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (adv) begin
                    cmsb_q <= cmsb_d;
                end
            end
        end
    end

    // Whole pipeline moves unless a valid result is waiting on the consumer.
    assign adv           = ~g_stg[STAGES-1].valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_stg[STAGES-1].valid_q;
    assign bus.sum       = g_stg[STAGES-1].sum_q;
    assign bus.cout      = g_stg[STAGES-1].carry_q;
    assign bus.ovf       = g_stg[STAGES-1].g_msb.cmsb_q ^ g_stg[STAGES-1].carry_q;

endmodule
